// File: rtl/bits8_word32_c.sv
// bits8_word32_c -- byte-to-word deserializer in the clk_4f_c domain.
// This block collects DATA_W-bit bytes, most significant byte first, into
// words that are WORD_BYTES bytes wide. Each completed word is presented
// for a valid window of WORD_BYTES cycles. A gap in the middle of a word
// drops the partial bytes and raises a one-cycle abort pulse.
//
// Ports
//   clk_4f_c     byte-rate clock (4x word rate)
//   reset        synchronous, active-low
//   valid_in     Data_in carries a byte this cycle
//   Data_in      input byte
//   valid_out_c  Data_out_c holds a freshly completed word
//   Data_out_c   last assembled word (held until the next completion or reset)
//   word_stb_c   1-cycle pulse on the first cycle of a new Data_out_c
//   abort_c      1-cycle pulse when a partial word is discarded
//   words_rx_c   completed-word counter, wraps
module bits8_word32_c #(
  parameter int DATA_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                         clk_4f_c,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [DATA_W-1:0]            Data_in,
  output logic                         valid_out_c,
  output logic [DATA_W*WORD_BYTES-1:0] Data_out_c,
  output logic                         word_stb_c,
  output logic                         abort_c,
  output logic [CNT_W-1:0]             words_rx_c
);

  localparam int W    = DATA_W * WORD_BYTES;
  localparam int BC_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int HC_W = $clog2(WORD_BYTES + 1);

  logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic [W-1:0]     data_q, data_d;
  logic             stb_q, stb_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             last_byte;

  assign last_byte = (byte_cnt_q == BC_W'(WORD_BYTES - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    hold_d     = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
    data_d     = data_q;
    stb_d      = 1'b0;
    abort_d    = 1'b0;
    words_d    = words_q;
    if (valid_in) begin
      // byte k lands in slice k counted from the MSB end
      for (int k = 0; k < WORD_BYTES; k++)
        if (byte_cnt_q == BC_W'(k))
          shift_d[W-1-k*DATA_W -: DATA_W] = Data_in;
      if (last_byte) begin
        // shift_d already contains the current byte in its low slice
        data_d     = shift_d;
        stb_d      = 1'b1;
        words_d    = words_q + 1'b1;
        byte_cnt_d = '0;
        // reload wins over the decrement, which keeps a stream's window unbroken
        hold_d     = HC_W'(WORD_BYTES);
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (byte_cnt_q != '0) begin
      byte_cnt_d = '0;
      abort_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_4f_c) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      stb_q      <= 1'b0;
      abort_q    <= 1'b0;
      words_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      data_q     <= data_d;
      stb_q      <= stb_d;
      abort_q    <= abort_d;
      words_q    <= words_d;
    end
  end

  assign valid_out_c = (hold_q != '0);
  assign Data_out_c  = data_q;
  assign word_stb_c  = stb_q;
  assign abort_c     = abort_q;
  assign words_rx_c  = words_q;

endmodule

// File: tb/tb_bits8_word32_c.sv
module tb_bits8_word32_c;

  logic        clk_4f_c = 1'b0;
  logic        reset    = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  Data_in  = '0;
  logic        valid_out_c;
  logic [31:0] Data_out_c;
  logic        word_stb_c;
  logic        abort_c;
  logic [3:0]  words_rx_c;

  bits8_word32_c #(.DATA_W(8), .WORD_BYTES(4), .CNT_W(4)) dut (
    .clk_4f_c   (clk_4f_c),
    .reset      (reset),
    .valid_in   (valid_in),
    .Data_in    (Data_in),
    .valid_out_c(valid_out_c),
    .Data_out_c (Data_out_c),
    .word_stb_c (word_stb_c),
    .abort_c    (abort_c),
    .words_rx_c (words_rx_c)
  );

  always #5 clk_4f_c = ~clk_4f_c;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  c;
  } exp_t;

  exp_t sb[$];
  int   stimes[$];
  int   errors = 0, checks = 0;
  int   exp_cnt = 0;
  int   cyc_n = 0, vcnt = 0, vfall = 0, acnt = 0;
  logic vprev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: counts window/abort activity and scores each word strobe
  always @(negedge clk_4f_c) begin
    exp_t e;
    cyc_n++;
    if (valid_out_c === 1'b1) vcnt++;
    if (vprev && valid_out_c !== 1'b1) vfall++;
    vprev = (valid_out_c === 1'b1);
    if (abort_c === 1'b1) acnt++;
    if (word_stb_c === 1'b1) begin
      stimes.push_back(cyc_n);
      if (sb.size() == 0) begin
        chk("stb_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("word_data", Data_out_c, e.w);
        chk("word_count", {28'd0, words_rx_c}, {28'd0, e.c});
        chk("word_valid", {31'd0, valid_out_c}, 32'd1);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    valid_in = v;
    Data_in  = d;
    @(posedge clk_4f_c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_t e;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) begin
        exp_cnt = (exp_cnt + 1) % 16;
        e.w = w;
        e.c = 4'(exp_cnt);
        sb.push_back(e);
      end
      cyc(1'b1, w[31-8*b -: 8]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_out_c}, 32'd0);
    chk({tag, "_data"},  Data_out_c, 32'd0);
    chk({tag, "_stb"},   {31'd0, word_stb_c}, 32'd0);
    chk({tag, "_abort"}, {31'd0, abort_c}, 32'd0);
    chk({tag, "_words"}, {28'd0, words_rx_c}, 32'd0);
  endtask

  initial begin
    int v0, f0, s0, a0;
    // 1) reset
    reset = 1'b0;
    idle(2);
    chk_zero("rst");
    reset = 1'b1;
    idle(2);

    // 2) single word
    v0 = vcnt; f0 = vfall; s0 = stimes.size();
    send_word(32'hAABBCCDD);
    idle(8);
    chk("t2_valid_cycles", 32'(vcnt - v0), 32'd4);
    chk("t2_windows", 32'(vfall - f0), 32'd1);
    chk("t2_strobes", 32'(stimes.size() - s0), 32'd1);
    chk("t2_words", {28'd0, words_rx_c}, 32'd1);

    // 3) three back-to-back words
    v0 = vcnt; f0 = vfall; s0 = stimes.size();
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    idle(8);
    chk("t3_valid_cycles", 32'(vcnt - v0), 32'd12);
    chk("t3_windows", 32'(vfall - f0), 32'd1);
    chk("t3_strobes", 32'(stimes.size() - s0), 32'd3);
    if (stimes.size() - s0 == 3) begin
      chk("t3_gap1", 32'(stimes[s0+1] - stimes[s0]), 32'd4);
      chk("t3_gap2", 32'(stimes[s0+2] - stimes[s0+1]), 32'd4);
    end
    chk("t3_words", {28'd0, words_rx_c}, 32'd4);
    chk("t3_hold", Data_out_c, 32'h090A0B0C);

    // 4) abort after two bytes
    a0 = acnt;
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    cyc(1'b0, 8'h00);
    idle(2);
    chk("t4_abort", 32'(acnt - a0), 32'd1);
    chk("t4_data_kept", Data_out_c, 32'h090A0B0C);
    chk("t4_words_kept", {28'd0, words_rx_c}, 32'd4);
    send_word(32'h33445566);
    idle(6);
    chk("t4_no_extra_abort", 32'(acnt - a0), 32'd1);
    chk("t4_data", Data_out_c, 32'h33445566);

    // 5) reset mid-word, with valid_in still asserted during reset
    a0 = acnt;
    cyc(1'b1, 8'h77);
    cyc(1'b1, 8'h88);
    reset = 1'b0;
    cyc(1'b1, 8'h99);
    chk_zero("t5_rst");
    reset = 1'b1;
    exp_cnt = 0;
    idle(2);
    chk("t5_no_abort", 32'(acnt - a0), 32'd0);
    send_word(32'hDEADBEEF);
    idle(6);
    chk("t5_data", Data_out_c, 32'hDEADBEEF);
    chk("t5_words", {28'd0, words_rx_c}, 32'd1);

    // 6) counter wrap: 15 more words take the 4-bit count from 1 through 15 to 0
    for (int i = 0; i < 15; i++) send_word(32'h10203040 + 32'(i));
    idle(8);
    chk("t6_wrap", {28'd0, words_rx_c}, 32'd0);
    chk("t6_data", Data_out_c, 32'h1020304E);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
